// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared types, image constants and bin mapping helpers for the LBP histogram
//
// Contents:
//   lbp_state_e      : histogram FSM states
//   IMG_DIM/LAST_IDX : image geometry
//   NBINS, BIN_W     : number of histogram bins and bits needed to index them
//   lbp_is_uniform   : true when a code has at most 2 transitions around the neighbour circle
//   lbp_uniform_idx  : rotation-uniform bin index for a code
// Build option: LBP_HIST_UNIFORM_EN selects the 59-bin uniform histogram.
package lbp_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } lbp_state_e;

    localparam int IMG_DIM  = 128;
    localparam int LAST_IDX = 127;

`ifdef LBP_HIST_UNIFORM_EN
    localparam int NBINS = 59;
`else
    localparam int NBINS = 256;
`endif

    localparam int BIN_W      = $clog2(NBINS);
    localparam int NONUNI_IDX = 58;

    // The code bits are not stored in circular order: walking round the
    // pixel the neighbours are TL, T, TR, R, BR, B, BL, L = b0 b1 b2 b4 b7 b6 b5 b3.
    function automatic logic lbp_is_uniform(logic [7:0] c);
        logic [7:0] s;
        logic [7:0] r;
        int         t;
        s = {c[3], c[5], c[6], c[7], c[4], c[2], c[1], c[0]};
        r = {s[0], s[7:1]};
        t = 0;
        for (int i = 0; i < 8; i++) begin
            if (s[i] != r[i]) begin
                t++;
            end
        end
        return (t <= 2);
    endfunction

    // Uniform codes are ranked in ascending raw-code order; the loop bound is
    // constant so this elaborates to a fixed comparator/adder network.
    function automatic logic [7:0] lbp_uniform_idx(logic [7:0] code);
        logic [7:0] idx;
        idx = '0;
        if (!lbp_is_uniform(code)) begin
            idx = 8'(NONUNI_IDX);
        end else begin
            for (int i = 0; i < 256; i++) begin
                if ((8'(i) < code) && lbp_is_uniform(8'(i))) begin
                    idx = idx + 8'd1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lbp_bin_map.sv
// rtl/lbp_bin_map.sv - combinational LBP code to bin mapping and image border detection
//
// Ports:
//   addr_i   [13:0] : pixel address {row, col}, col is the low COL_W bits
//   code_i   [7:0]  : LBP code
//   bin_o    [7:0]  : histogram bin index for code_i
//   border_o        : address lies on the first/last row or column
// Build option: LBP_HIST_UNIFORM_EN selects rotation-uniform mapping, else identity.
module lbp_bin_map
    import lbp_pkg::*;
#(
    parameter int COL_W = 7
) (
    input  logic [13:0] addr_i,
    input  logic [7:0]  code_i,
    output logic [7:0]  bin_o,
    output logic        border_o
);

    localparam int ROW_W = 14 - COL_W;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LAST_IDX);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LAST_IDX);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    assign row = addr_i[13:COL_W];
    assign col = addr_i[COL_W-1:0];

    assign border_o = (row == '0) || (row == ROW_LAST) ||
                      (col == '0) || (col == COL_LAST);

`ifdef LBP_HIST_UNIFORM_EN
    assign bin_o = lbp_uniform_idx(code_i);
`else
    assign bin_o = code_i;
`endif

endmodule

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - LBP code histogram: accumulate one image, then stream the bins out
//
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   lbp_valid/lbp_addr/lbp_data  : incoming LBP sample stream
//   finish                       : level, engine has produced its last sample
//   hist_valid/hist_ready        : bin output handshake
//   hist_addr/hist_data          : bin index and saturating count
//   hist_done                    : sticky, every bin has been transferred
//   hist_err                     : sticky, a border-address sample was dropped
// Build option: LBP_HIST_UNIFORM_EN selects the 59-bin rotation-uniform histogram.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14,
    parameter int COL_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_addr,
    output logic [CNT_W-1:0] hist_data,
    output logic             hist_done,
    output logic             hist_err
);

    lbp_state_e state_q, state_d;
    logic       drain_q, drain_d;
    logic [7:0] rd_q, rd_d;

    logic       s1_keep_q;
    logic [7:0] s1_idx_q;
    logic       err_q;

    logic [CNT_W-1:0] bins_q [NBINS];

    logic [7:0] map_bin;
    logic       map_border;
    logic       take;

    lbp_bin_map #(
        .COL_W (COL_W)
    ) u_map (
        .addr_i   (lbp_addr),
        .code_i   (lbp_data),
        .bin_o    (map_bin),
        .border_o (map_border)
    );

    // Samples are accepted only while accumulating, including the cycle
    // finish is first seen.
    assign take = (state_q == ST_ACCUM) && lbp_valid;

    // S1: register mapped bin and whether it should be counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_keep_q <= 1'b0;
            s1_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            s1_keep_q <= take && !map_border;
            s1_idx_q  <= map_bin;
            err_q     <= err_q || (take && map_border);
        end
    end

    // S2: read-modify-write of one bin per cycle. The read sees the array
    // after any update from the previous cycle, so repeated hits on one bin
    // need no forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBINS; i++) begin
                bins_q[i] <= '0;
            end
        end else if (s1_keep_q && (bins_q[s1_idx_q[BIN_W-1:0]] != '1)) begin
            bins_q[s1_idx_q[BIN_W-1:0]] <= bins_q[s1_idx_q[BIN_W-1:0]] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            drain_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            rd_q    <= rd_d;
        end
    end

    // The two drain cycles let the last accepted sample pass through S1/S2
    // before bin 0 is presented.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        rd_d       = rd_q;
        hist_valid = 1'b0;
        hist_done  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (finish) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                hist_valid = 1'b1;
                if (hist_ready) begin
                    if (rd_q == 8'(NBINS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_d = rd_q + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                hist_done = 1'b1;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    assign hist_addr = rd_q;
    assign hist_data = (state_q == ST_READ) ? bins_q[rd_q[BIN_W-1:0]] : '0;
    assign hist_err  = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - directed self-checking bench for lbp_hist
module tb_lbp_hist;

    localparam int CNT_W = 14;
`ifdef LBP_HIST_UNIFORM_EN
    localparam int NB     = 59;
    localparam int BIN_05 = 58;
`else
    localparam int NB     = 256;
    localparam int BIN_05 = 5;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             lbp_valid = 1'b0;
    logic [13:0]      lbp_addr = '0;
    logic [7:0]       lbp_data = '0;
    logic             finish = 1'b0;
    logic             hist_valid;
    logic             hist_ready = 1'b0;
    logic [7:0]       hist_addr;
    logic [CNT_W-1:0] hist_data;
    logic             hist_done;
    logic             hist_err;

    int errors = 0;
    int checks = 0;
    int exp_bins [256];
    int got [256];

    always #5 clk = ~clk;

    lbp_hist #(
        .CNT_W (CNT_W),
        .COL_W (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_addr  (hist_addr),
        .hist_data  (hist_data),
        .hist_done  (hist_done),
        .hist_err   (hist_err)
    );

    task automatic clear_exp();
        for (int i = 0; i < 256; i++) begin
            exp_bins[i] = 0;
            got[i] = -1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        lbp_valid = 1'b0;
        finish = 1'b0;
        hist_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input int row, input int col, input logic [7:0] code);
        logic [6:0] r7;
        logic [6:0] c7;
        r7 = 7'(row);
        c7 = 7'(col);
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_addr = {r7, c7};
        lbp_data = code;
    endtask

    // Raise finish and count cycles until hist_valid; a sample offered in the
    // first drain cycle must be ignored.
    task automatic start_read(output int lat);
        @(negedge clk);
        lbp_valid = 1'b0;
        finish = 1'b1;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            if (k == 0) begin
                lbp_valid = 1'b1;
                lbp_addr = {7'd1, 7'd1};
                lbp_data = 8'h05;
            end else begin
                lbp_valid = 1'b0;
            end
            if (hist_valid) break;
        end
    endtask

    // Entered on the negedge where hist_valid is first high.
    task automatic read_bins(input bit stall, input int stop_at);
        int         nxt;
        int         cyc;
        bit         pstall;
        logic [7:0] pa;
        logic [CNT_W-1:0] pd;
        nxt = 0;
        cyc = 0;
        pstall = 0;
        pa = '0;
        pd = '0;
        while (nxt < stop_at && cyc < 3000) begin
            if (pstall) begin
                checks++;
                if (hist_valid !== 1'b1 || hist_addr !== pa || hist_data !== pd) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b addr=%0d data=%0d, required valid=1 addr=%0d data=%0d",
                             hist_valid, hist_addr, hist_data, pa, pd);
                end
            end
            hist_ready = (stall && cyc < 8) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (hist_valid) begin
                if (hist_ready) begin
                    checks++;
                    if (hist_addr !== 8'(nxt)) begin
                        errors++;
                        $display("FAIL xfer_order: addr=%0d, required %0d", hist_addr, nxt);
                    end
                    got[nxt] = int'(hist_data);
                    nxt++;
                end
                pstall = !hist_ready;
                pa = hist_addr;
                pd = hist_data;
            end else begin
                pstall = 0;
            end
            cyc++;
            @(negedge clk);
        end
        hist_ready = 1'b0;
        checks++;
        if (nxt != stop_at) begin
            errors++;
            $display("FAIL read_timeout: transfers=%0d, required %0d", nxt, stop_at);
        end
        if (stop_at == NB) begin
            checks++;
            if (hist_valid !== 1'b0 || hist_done !== 1'b1) begin
                errors++;
                $display("FAIL done_flag: valid=%0b done=%0b, required valid=0 done=1", hist_valid, hist_done);
            end
        end
        for (int i = 0; i < stop_at; i++) begin
            checks++;
            if (got[i] != exp_bins[i]) begin
                errors++;
                $display("FAIL bin_count[%0d]: got %0d, required %0d", i, got[i], exp_bins[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (hist_valid !== 1'b0 || hist_done !== 1'b0 || hist_err !== 1'b0 ||
            hist_addr !== 8'd0 || hist_data !== '0) begin
            errors++;
            $display("FAIL reset_values: valid=%0b done=%0b err=%0b addr=%0d data=%0d, required all 0",
                     hist_valid, hist_done, hist_err, hist_addr, hist_data);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (hist_valid !== 1'b0 || hist_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%0b done=%0b, required 0 0", hist_valid, hist_done);
        end
    endtask

    task automatic test_basic_border_stall();
        int lat;
        do_reset();
        clear_exp();
        for (int k = 0; k < 3; k++) send(1, 1, 8'h05);
        exp_bins[BIN_05] = 3;
        @(negedge clk);
        checks++;
        if (hist_err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: err=%0b, required 0", hist_err);
        end
        lbp_valid = 1'b1;
        lbp_addr = {7'd0, 7'd5};
        lbp_data = 8'h07;
        @(negedge clk);
        checks++;
        if (hist_err !== 1'b1) begin
            errors++;
            $display("FAIL err_rise: err=%0b, required 1", hist_err);
        end
        lbp_addr = {7'd5, 7'd127};
        lbp_data = 8'h09;
        start_read(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL read_latency: cycles=%0d, required 3", lat);
        end
        checks++;
        if (hist_addr !== 8'd0) begin
            errors++;
            $display("FAIL first_addr: addr=%0d, required 0", hist_addr);
        end
        read_bins(1'b1, NB);
        checks++;
        if (hist_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%0b, required 1", hist_err);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat;
        do_reset();
        clear_exp();
        send(2, 3, 8'h03);
        exp_bins[3] = 1;
        start_read(lat);
        read_bins(1'b0, 10);
        reset = 1'b1;
        finish = 1'b0;
        lbp_valid = 1'b0;
        #1;
        checks++;
        if (hist_valid !== 1'b0 || hist_done !== 1'b0 || hist_err !== 1'b0 ||
            hist_addr !== 8'd0 || hist_data !== '0) begin
            errors++;
            $display("FAIL abort_reset: valid=%0b done=%0b err=%0b addr=%0d data=%0d, required all 0",
                     hist_valid, hist_done, hist_err, hist_addr, hist_data);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_exp();
        send(3, 4, 8'h04);
        exp_bins[4] = 1;
        start_read(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL restart_latency: cycles=%0d, required 3", lat);
        end
        read_bins(1'b0, NB);
    endtask

`ifdef LBP_HIST_UNIFORM_EN
    task automatic test_uniform();
        int lat;
        do_reset();
        clear_exp();
        send(10, 10, 8'h00);
        send(10, 11, 8'h01);
        send(10, 12, 8'h03);
        send(10, 13, 8'h04);
        send(10, 14, 8'hFF);
        exp_bins[0] = 1;
        exp_bins[1] = 1;
        exp_bins[3] = 1;
        exp_bins[4] = 1;
        exp_bins[57] = 1;
        start_read(lat);
        read_bins(1'b0, NB);
    endtask
`endif

    task automatic test_raster();
        int lat;
        do_reset();
        clear_exp();
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                send(r, c, 8'h00);
            end
        end
        exp_bins[0] = 15876;
        start_read(lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL raster_latency: cycles=%0d, required 3", lat);
        end
        checks++;
        if (hist_err !== 1'b0) begin
            errors++;
            $display("FAIL raster_err: err=%0b, required 0", hist_err);
        end
        read_bins(1'b0, NB);
    endtask

    initial begin
        test_reset();
        test_basic_border_stall();
        test_reset_mid_read();
`ifdef LBP_HIST_UNIFORM_EN
        test_uniform();
`endif
        test_raster();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
